mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/mmio_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART TX register window: store/load address, data,
// byte enables, combinational read data and window hit.
interface mmio_uart_tx_if;
  logic [3:0]  we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;

  modport master (output we, a, wd, input rd, hit);
  modport slave  (input we, a, wd, output rd, hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA stores fill a byte FIFO which a
// four-state serial FSM drains at a programmable cycles-per-bit divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic            clk,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_div, r_cnt, w_cnt_nx, w_div_eff;
  logic [2:0]    r_idx, w_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_tx, w_tx_nx, w_pop;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_hit, w_wr, w_data_wr, w_push, w_full, w_empty, w_ovf_clr;
  logic [1:0]    w_sel;
  logic [7:0]    w_count8;
  logic [31:0]   w_rd;
  logic          w_unused;

  assign w_hit     = (bus.a[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = bus.a[3:2];
  assign w_wr      = w_hit && (bus.we != 4'b0000);
  assign w_data_wr = w_wr && (w_sel == 2'd0) && bus.we[0];
  assign w_ovf_clr = w_wr && (w_sel == 2'd1) && bus.we[0] && bus.wd[3];
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // A full FIFO still accepts a store when the transmitter pops on the same edge.
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_count8  = 8'(r_count);
  assign w_unused  = &{1'b0, bus.a[1:0], bus.wd[31:16]};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rptr];
          w_cnt_nx   = w_div_eff - 16'd1;
          w_tx_nx    = 1'b0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (r_cnt == 16'd0) begin
          w_cnt_nx   = w_div_eff - 16'd1;
          w_idx_nx   = 3'd0;
          w_tx_nx    = r_shift[0];
          w_state_nx = S_DATA;
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == 16'd0) begin
          w_cnt_nx = w_div_eff - 16'd1;
          if (r_idx == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_idx_nx   = r_idx + 3'd1;
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_tx_nx    = r_shift[1];
          end
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == 16'd0) begin
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rptr];
            w_cnt_nx   = w_div_eff - 16'd1;
            w_idx_nx   = 3'd0;
            w_tx_nx    = 1'b0;
            w_state_nx = S_START;
          end else begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_data_wr && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ovf_clr)                r_ovf <= 1'b0;
      if (w_wr && (w_sel == 2'd2)) begin
        if (bus.we[0]) r_div[7:0]  <= bus.wd[7:0];
        if (bus.we[1]) r_div[15:8] <= bus.wd[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wd[7:0];
    r_shift <= w_shift_nx;
  end

  always_comb begin
    w_rd = 32'd0;
    if (w_hit) begin
      case (w_sel)
        2'd1:    w_rd = {16'd0, w_count8, 4'd0, r_ovf, w_empty, w_full, (r_state != S_IDLE)};
        2'd2:    w_rd = {16'd0, r_div};
        default: w_rd = 32'd0;
      endcase
    end
  end

  assign bus.rd  = w_rd;
  assign bus.hit = w_hit;
  assign tx      = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode, frame timing, FIFO
// back-to-back draining, overflow handling and reset during a frame.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  int   vectors = 0;
  int   miscompares = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.a  = addr;
    bus.wd = data;
    bus.we = be;
    @(posedge clk); #1;
    bus.we = 4'b0000;
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] data);
    bus.a  = addr;
    bus.we = 4'b0000;
    #1;
    data = bus.rd;
  endtask

  // Expected line level k cycles after the first pop edge for n back-to-back frames.
  function automatic logic exp_tx(int k, int div, logic [31:0] bytes, int n);
    int f, slot;
    if (k >= n * 10 * div) return 1'b1;
    f    = k / (10 * div);
    slot = (k % (10 * div)) / div;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return bytes[f * 8 + slot - 1];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    bus.we = 4'b0000; bus.a = 32'd0; bus.wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
    reset = 1'b0;
    @(posedge clk); #1;
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
    vectors++;
    if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL reset_hit: got %b expected 1", bus.hit); end
    rdreg(BASE + 32'd8, d);
    vectors++;
    if (d !== 32'd16) begin miscompares++; $display("FAIL reset_div: got %h expected %h", d, 32'd16); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (tx !== 1'b1) begin miscompares++; $display("FAIL idle_tx[%0d]: got %b expected 1", i, tx); end
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(BASE + 32'd12, 32'hFFFF_FFFF, 4'b1111);
    rdreg(BASE + 32'd12, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL reserved_rd: got %h expected 0", d); end
    wr(32'h0000_0040, 32'h0000_0033, 4'b1111);
    wr(32'h0000_0048, 32'h0000_0007, 4'b1111);
    rdreg(32'h0000_0040, d);
    vectors++;
    if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL outside_hit: got %b expected 0", bus.hit); end
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL outside_rd: got %h expected 0", d); end
    rdreg(BASE + 32'd8, d);
    vectors++;
    if (d !== 32'd16) begin miscompares++; $display("FAIL outside_div: got %h expected %h", d, 32'd16); end
    wr(BASE, 32'h0000_1234, 4'b0010);
    @(posedge clk); #1;
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL no_push_status: got %h expected %h", d, 32'h4); end
    wr(BASE + 32'd8, 32'h0000_0300, 4'b0010);
    rdreg(BASE + 32'd8, d);
    vectors++;
    if (d !== 32'h0000_0310) begin miscompares++; $display("FAIL div_lane1: got %h expected %h", d, 32'h310); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    wr(BASE + 32'd8, 32'd4, 4'b0011);
    wr(BASE, 32'h0000_0055, 4'b0001);
    for (int k = 0; k < 44; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (tx !== exp_tx(k, 4, 32'h55, 1)) begin
        miscompares++; $display("FAIL frame55_tx[%0d]: got %b expected %b", k, tx, exp_tx(k, 4, 32'h55, 1));
      end
      rdreg(BASE + 32'd4, d);
      vectors++;
      if (d[0] !== (k < 40)) begin
        miscompares++; $display("FAIL frame55_busy[%0d]: got %b expected %b", k, d[0], (k < 40));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] bytes = 32'h00C3_B2A1;
    int peak = 0;
    wr(BASE + 32'd8, 32'd2, 4'b0011);
    bus.a = BASE; bus.we = 4'b0001;
    bus.wd = 32'hA1; @(posedge clk); #1;
    bus.wd = 32'hB2; @(posedge clk); #1;
    vectors++;
    if (tx !== 1'b0) begin miscompares++; $display("FAIL b2b_tx[0]: got %b expected 0", tx); end
    bus.wd = 32'hC3; @(posedge clk); #1;
    bus.we = 4'b0000;
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d[15:8] !== 8'd2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", d[15:8]); end
    for (int k = 1; k < 64; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      vectors++;
      if (tx !== exp_tx(k, 2, bytes, 3)) begin
        miscompares++; $display("FAIL b2b_tx[%0d]: got %b expected %b", k, tx, exp_tx(k, 2, bytes, 3));
      end
      rdreg(BASE + 32'd4, d);
      if (int'(d[15:8]) > peak) peak = int'(d[15:8]);
    end
    vectors++;
    if (peak !== 2) begin miscompares++; $display("FAIL b2b_peak: got %0d expected 2", peak); end
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL b2b_end_status: got %h expected %h", d, 32'h4); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int prev = 8;
    int drops = 0;
    wr(BASE + 32'd8, 32'd1000, 4'b0011);
    bus.a = BASE; bus.we = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      bus.wd = 32'h10 + i;
      @(posedge clk); #1;
    end
    bus.we = 4'b0000;
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d !== 32'h0000_080B) begin miscompares++; $display("FAIL ovf_status: got %h expected %h", d, 32'h80B); end
    wr(BASE + 32'd4, 32'h8, 4'b0001);
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d !== 32'h0000_0803) begin miscompares++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h803); end
    wr(BASE + 32'd8, 32'd0, 4'b0011);
    rdreg(BASE + 32'd8, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL div_zero: got %h expected 0", d); end
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      rdreg(BASE + 32'd4, d);
      if (int'(d[15:8]) < prev) drops++;
      prev = int'(d[15:8]);
      if (d == 32'h4) break;
    end
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL drain_status: got %h expected %h", d, 32'h4); end
    vectors++;
    if (drops !== 8) begin miscompares++; $display("FAIL drain_pops: got %0d expected 8", drops); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [31:0] bytes = 32'h0096_5A3C;
    wr(BASE + 32'd8, 32'd8, 4'b0011);
    bus.a = BASE; bus.we = 4'b0001;
    bus.wd = 32'h3C; @(posedge clk); #1;
    bus.wd = 32'h5A; @(posedge clk); #1;
    bus.wd = 32'h96; @(posedge clk); #1;
    bus.we = 4'b0000;
    for (int k = 1; k < 30; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      vectors++;
      if (tx !== exp_tx(k, 8, bytes, 3)) begin
        miscompares++; $display("FAIL rst_frame_tx[%0d]: got %b expected %b", k, tx, exp_tx(k, 8, bytes, 3));
      end
    end
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d[15:8] !== 8'd2) begin miscompares++; $display("FAIL rst_pre_count: got %0d expected 2", d[15:8]); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_tx: got %b expected 1", tx); end
    rdreg(BASE + 32'd4, d);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL rst_status: got %h expected %h", d, 32'h4); end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_quiet_tx[%0d]: got %b expected 1", i, tx); end
    end
    rdreg(BASE + 32'd8, d);
    vectors++;
    if (d !== 32'd16) begin miscompares++; $display("FAIL rst_div: got %h expected %h", d, 32'd16); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
